// File: rtl/vce_pkg.sv
// Shared definitions for the VCE CPU register file and CRAM sequencer.
package vce_pkg;

  localparam int CRAM_AW = 9;
  localparam int CRAM_DW = 9;

  localparam logic [2:0] VCE_CR      = 3'd0;
  localparam logic [2:0] VCE_ADDR_LO = 3'd2;
  localparam logic [2:0] VCE_ADDR_HI = 3'd3;
  localparam logic [2:0] VCE_DATA_LO = 3'd4;
  localparam logic [2:0] VCE_DATA_HI = 3'd5;

  typedef enum logic [2:0] {IDLE, WR_PEND, RD_ISSUE, RD_CAP, HOLD} vce_state_t;

  typedef logic [CRAM_DW-1:0] cram_word_t;

  // The high data port reads back as all ones apart from the colour MSB.
  function automatic logic [7:0] fmt_rdata(input logic [2:0] a, input cram_word_t w);
    return (a == VCE_DATA_HI) ? {7'h7F, w[CRAM_DW-1]} : w[7:0];
  endfunction

endpackage

// File: rtl/vce_cram_arb.sv
// CRAM port arbiter: pixel lookups win the single port; CPU gets the free cycles.
module vce_cram_arb
  import vce_pkg::*;
#(
  parameter int CRAM_AW = 9,
  parameter int CRAM_DW = 9
) (
  input  logic               clock,
  input  logic               reset_N,
  input  logic               pix_req,
  input  logic [CRAM_AW-1:0] VD,
  input  logic [CRAM_AW-1:0] cpu_addr,
  input  logic [CRAM_DW-1:0] cpu_wdata,
  input  logic               cpu_we,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [CRAM_DW-1:0] cram_wdata,
  output logic               cram_we,
  input  logic [CRAM_DW-1:0] cram_rdata,
  output logic [CRAM_DW-1:0] pix_data,
  output logic               pix_valid
);

  logic vld_p1;

  assign cram_addr  = pix_req ? VD : cpu_addr;
  assign cram_we    = cpu_we & ~pix_req;
  assign cram_wdata = cpu_wdata;

  // p1: RAM access in flight; p2: read data registered as the pixel colour
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      vld_p1    <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      vld_p1    <= pix_req;
      pix_valid <= vld_p1;
      if (vld_p1)
        pix_data <= cram_rdata;
    end
  end

endmodule

// File: rtl/vce_cram_ctrl.sv
// HuC6260 VCE CPU register file and CRAM access sequencer.
module vce_cram_ctrl
  import vce_pkg::*;
#(
  parameter int CRAM_AW = 9,
  parameter int CRAM_DW = 9
) (
  input  logic               clock,
  input  logic               reset_N,
  input  logic [2:0]         A,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  input  logic               CS_n,
  input  logic               RD_n,
  input  logic               WR_n,
  input  logic               pix_req,
  input  logic [CRAM_AW-1:0] VD,
  output logic [CRAM_DW-1:0] pix_data,
  output logic               pix_valid,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [CRAM_DW-1:0] cram_wdata,
  output logic               cram_we,
  input  logic [CRAM_DW-1:0] cram_rdata,
  output logic [7:0]         CR,
  output logic               cpu_busy
);

  vce_state_t         state;
  logic [2:0]         a_q;
  logic               din0_q;
  logic [CRAM_AW-1:0] addr;
  logic [7:0]         wlatch;
  logic               strobe;

  assign strobe   = ~CS_n & (~RD_n | ~WR_n);
  assign cpu_busy = (state == WR_PEND) | (state == RD_ISSUE) | (state == RD_CAP);

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state  <= IDLE;
      a_q    <= '0;
      din0_q <= 1'b0;
      addr   <= '0;
      wlatch <= '0;
      CR     <= '0;
      dout   <= 8'hFF;
    end else begin
      case (state)
        IDLE: if (strobe) begin
          a_q    <= A;
          din0_q <= din[0];
          if (!WR_n) begin
            state <= HOLD;
            case (A)
              VCE_CR:      CR <= din;
              VCE_ADDR_LO: addr[7:0] <= din;
              VCE_ADDR_HI: addr[CRAM_AW-1] <= din[0];
              VCE_DATA_LO: wlatch <= din;
              VCE_DATA_HI: state <= WR_PEND;
              default: ;
            endcase
          end else if (A == VCE_DATA_LO || A == VCE_DATA_HI) begin
            state <= RD_ISSUE;
          end else begin
            dout  <= 8'hFF;
            state <= HOLD;
          end
        end
        // The write strobe itself is combinational in the arbiter on this state.
        WR_PEND: if (!pix_req) begin
          addr  <= addr + 1'b1;
          state <= HOLD;
        end
        RD_ISSUE: if (!pix_req) state <= RD_CAP;
        RD_CAP: begin
          dout <= fmt_rdata(a_q, cram_rdata);
          if (a_q == VCE_DATA_HI)
            addr <= addr + 1'b1;
          state <= HOLD;
        end
        HOLD: if (RD_n && WR_n) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  vce_cram_arb #(.CRAM_AW(CRAM_AW), .CRAM_DW(CRAM_DW)) u_arb (
    .clock      (clock),
    .reset_N    (reset_N),
    .pix_req    (pix_req),
    .VD         (VD),
    .cpu_addr   (addr),
    .cpu_wdata  ({din0_q, wlatch}),
    .cpu_we     (state == WR_PEND),
    .cram_addr  (cram_addr),
    .cram_wdata (cram_wdata),
    .cram_we    (cram_we),
    .cram_rdata (cram_rdata),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid)
  );

endmodule

// File: doc/vce_cram_ctrl.md
Name: vce_cram_ctrl

Overview:
- CPU-side register file and CRAM access sequencer for the HuC6260 VCE.
- Decodes CPU register strobes: control, CRAM address low/high, CRAM data low/high.
- Shares one single-port synchronous CRAM between the pixel lookup path (driven by VDC pixel data VD) and CPU reads/writes; the pixel path always has priority.
- Exports the control-register fields (dot-clock mode and others) to the clock divider and colour output stage.

Parameters:
- CRAM_AW, 9, CRAM address width (512 entries).
- CRAM_DW, 9, CRAM word width (GGGRRRBBB).

Ports:
- clock  in  1  master clock.
- reset_N  in  1  asynchronous active-low reset.
- A  in  3  CPU register select.
- din  in  8  CPU write data.
- dout  out  8  CPU read data; the top level drives D from this while RD_n is low.
- CS_n  in  1  chip select, active low.
- RD_n  in  1  read strobe, active low.
- WR_n  in  1  write strobe, active low.
- pix_req  in  1  pixel lookup request this cycle.
- VD  in  9  pixel CRAM index.
- pix_data  out  9  looked-up colour.
- pix_valid  out  1  pix_data updated this cycle.
- cram_addr  out  9  CRAM address.
- cram_wdata  out  9  CRAM write data.
- cram_we  out  1  CRAM write enable.
- cram_rdata  in  9  CRAM read data, valid 1 cycle after the address.
- CR  out  8  control register; CR[1:0] is the dot-clock mode.
- cpu_busy  out  1  a CPU CRAM access is pending.

Behaviour:
- Reset values: CR=0, cram address register=0, write latch=0, dout=8'hFF, pix_data=0, pix_valid=0, cram_we=0, cpu_busy=0; FSM in IDLE.
- A reset mid-access abandons the access; no CRAM write is issued.
- Strobe detection: a strobe is accepted in IDLE on the first clock where CS_n=0 and (RD_n=0 or WR_n=0). If both strobes are low, WR_n wins.

Register map (write side):
- A=0: CR <= din.
- A=2: addr[7:0] <= din.
- A=3: addr[8] <= din[0].
- A=4: wlatch <= din.
- A=5: commit CRAM write of {din[0], wlatch} at addr, then addr <= addr+1.
- A=1,6,7: writes ignored.

Register map (read side):
- A=4: dout <= {cram[addr][7:0]}.
- A=5: dout <= {7'h7F, cram[addr][8]}, then addr <= addr+1.
- Any other A: dout <= 8'hFF.

Address increment: addr wraps modulo 512 (0x1FF -> 0x000).

FSM:
- IDLE:
  - Accepted register-only access completes in 1 cycle, then go to HOLD.
  - A=5 write -> WR_PEND.
  - A=4/5 read -> RD_ISSUE.
- WR_PEND: waits while pix_req=1. On the first cycle with pix_req=0, assert cram_we with cram_addr=addr for exactly 1 cycle, increment addr, go to HOLD.
- RD_ISSUE: waits while pix_req=1. On a free cycle, drive cram_addr=addr, go to RD_CAP.
- RD_CAP: latch cram_rdata into dout (per the A=4/A=5 format), increment addr if A=5, go to HOLD.
- HOLD: stay until RD_n=1 and WR_n=1, then go to IDLE. This guarantees one action per strobe.
- A and din are captured at strobe acceptance and used for the whole access.
- cpu_busy=1 in WR_PEND, RD_ISSUE and RD_CAP.

Pixel path:
- When pix_req=1, cram_addr=VD and cram_we=0, regardless of FSM state.
- Pixel latency is 2 cycles: request at cycle N, cram_rdata at N+1, pix_data registered and pix_valid=1 at N+2.
- When there was no request, pix_valid=0 and pix_data holds its value.

Arbitration and hazards:
- Arbitration is purely combinational on pix_req.
- A CPU access may starve under continuous pix_req; this is accepted (the CPU writes during blanking).
- A pixel read and a CPU write to the same address never occur in the same cycle.
- A pixel read in the cycle after a CPU write to the same entry returns the new data (write-first RAM is required at the top level).

Decomposition:
- vce_pkg holds:
  - the register-select constants (VCE_CR=0, VCE_ADDR_LO=2, VCE_ADDR_HI=3, VCE_DATA_LO=4, VCE_DATA_HI=5);
  - the FSM state enum (IDLE, WR_PEND, RD_ISSUE, RD_CAP, HOLD);
  - the CRAM word typedef.
- One sub-module, vce_cram_arb: the pixel/CPU address mux, pix_valid pipeline and pix_data register.
- The register FSM stays in the top module.

Test Plan:
- Write A=2 din=0xFF, A=3 din=0x01, A=4 din=0xA5, A=5 din=0x01 with pix_req=0 -> one cram_we pulse at addr 0x1FF with data 0x1A5; addr wraps to 0x000.
- Set addr=0x010, write A=4 then A=5 twice (0x12/0x00, 0x34/0x01) -> CRAM[0x010]=0x012, CRAM[0x011]=0x134; addr=0x012.
- Preload CRAM[0x020]=0x1C3, set addr=0x020, read A=4 then A=5 -> dout=0xC3, then dout=0xFF; addr=0x021.
- Hold pix_req=1 for 5 cycles while an A=5 write is pending -> cpu_busy=1, no cram_we during those cycles; cram_we fires on the first cycle with pix_req=0.
- pix_req=1 with VD=0x005 at cycle N, CRAM[5]=0x0AA -> pix_valid=1 and pix_data=0x0AA at N+2.
- Hold WR_n low for 10 cycles on A=5 -> exactly one cram_we pulse and one increment. Assert reset_N=0 while in WR_PEND -> no write; CR=0, dout=0xFF.
